alu_exec_unit: RTL and testbench

Execute-stage arithmetic unit that consumes the 3-bit ALU control code produced by the ALU control decoder together with the two register operands. ADD/SUB/AND/OR complete in one cycle; MUL uses an iterative shift-add engine over WIDTH cycles. A valid/ready handshake lets the pipeline hazard logic stall IF/ID/EX while a multiply is in flight. Results and the zero flag are registered and held until the next completion.

---
 rtl/alu_exec_unit.sv | 113 +++++++++++
 tb/tb_alu_exec_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ADD/SUB/AND/OR and an iterative shift-add MUL
// that stalls the pipeline through a valid/ready handshake while in flight.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o,
  output logic             valid_o,
  output logic             stall_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] multiplicand, multiplier, acc, acc_next, simple_result;
  logic [CW-1:0]    count;
  logic             accept, last_step;

  assign accept    = valid_i && (state == IDLE);
  assign last_step = (count == LAST_STEP);
  assign acc_next  = multiplier[0] ? (acc + multiplicand) : acc;

  // Undefined control codes fall through to zero so they still complete cleanly.
  always_comb begin
    simple_result = '0;
    case (ALUCtrl_i)
      OP_ADD:  simple_result = data1_i + data2_i;
      OP_SUB:  simple_result = data1_i - data2_i;
      OP_AND:  simple_result = data1_i & data2_i;
      OP_OR:   simple_result = data1_i | data2_i;
      default: simple_result = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && (ALUCtrl_i == OP_MUL)) next_state = MUL;
      MUL:     if (last_step) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state == IDLE);
    stall_o = (state != IDLE);
  end

  // Result registers hold between completions; valid_o is a single-cycle strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o       <= '0;
      Zero_o       <= 1'b1;
      valid_o      <= 1'b0;
      multiplicand <= '0;
      multiplier   <= '0;
      acc          <= '0;
      count        <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (ALUCtrl_i == OP_MUL) begin
              multiplicand <= data1_i;
              multiplier   <= data2_i;
              acc          <= '0;
              count        <= '0;
            end else begin
              data_o  <= simple_result;
              Zero_o  <= (simple_result == '0);
              valid_o <= 1'b1;
            end
          end
        end
        MUL: begin
          acc          <= acc_next;
          multiplicand <= multiplicand << 1;
          multiplier   <= multiplier >> 1;
          count        <= count + 1'b1;
          if (last_step) begin
            data_o  <= acc_next;
            Zero_o  <= (acc_next == '0);
            valid_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed and randomized operations
// compared against a plain-arithmetic reference model.
module tb_alu_exec_unit;

  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [WIDTH-1:0] data1_i, data2_i;
  logic [2:0]       ALUCtrl_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data_o;
  logic             Zero_o;
  logic             valid_o;
  logic             stall_o;

  int total = 0;
  int bad   = 0;

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .ALUCtrl_i (ALUCtrl_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_o    (data_o),
    .Zero_o    (Zero_o),
    .valid_o   (valid_o),
    .stall_o   (stall_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference result of one operation, straight from the arithmetic definition.
  function automatic logic [WIDTH-1:0] ref_result(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    case (op)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b011:  return a * b;
      default: return '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_simple(input logic [2:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] exp;
    exp       = ref_result(op, a, b);
    valid_i   = 1'b1;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    tick();
    total++;
    if (valid_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL simple_valid op=%b got=%b want=1", op, valid_o);
    end
    total++;
    if (data_o !== exp) begin
      bad++;
      $display("[TB] FAIL simple_data op=%b a=%h b=%h got=%h want=%h", op, a, b, data_o, exp);
    end
    total++;
    if (Zero_o !== (exp == '0)) begin
      bad++;
      $display("[TB] FAIL simple_zero op=%b got=%b want=%b", op, Zero_o, (exp == '0));
    end
    total++;
    if (ready_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL simple_ready op=%b got=%b want=1", op, ready_o);
    end
  endtask

  task automatic do_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] exp;
    int busy;
    int early;
    exp       = a * b;
    valid_i   = 1'b1;
    ALUCtrl_i = 3'b011;
    data1_i   = a;
    data2_i   = b;
    tick();
    valid_i = 1'b0;
    busy    = 0;
    early   = 0;
    while (ready_o === 1'b0 && busy < 100) begin
      if (valid_o === 1'b1) early++;
      total++;
      if (stall_o !== 1'b1) begin
        bad++;
        $display("[TB] FAIL mul_stall cycle=%0d got=%b want=1", busy, stall_o);
      end
      busy++;
      tick();
    end
    total++;
    if (busy != WIDTH) begin
      bad++;
      $display("[TB] FAIL mul_busy_cycles got=%0d want=%0d", busy, WIDTH);
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("[TB] FAIL mul_early_valid got=%0d want=0", early);
    end
    total++;
    if (valid_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mul_valid got=%b want=1", valid_o);
    end
    total++;
    if (data_o !== exp) begin
      bad++;
      $display("[TB] FAIL mul_data a=%h b=%h got=%h want=%h", a, b, data_o, exp);
    end
    total++;
    if (Zero_o !== (exp == '0)) begin
      bad++;
      $display("[TB] FAIL mul_zero got=%b want=%b", Zero_o, (exp == '0));
    end
    tick();
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mul_single_pulse got=%b want=0", valid_o);
    end
    total++;
    if (data_o !== exp) begin
      bad++;
      $display("[TB] FAIL mul_hold got=%h want=%h", data_o, exp);
    end
  endtask

  task automatic test_reset();
    rst_i     = 1'b1;
    valid_i   = 1'b1;
    ALUCtrl_i = 3'b010;
    data1_i   = $urandom;
    data2_i   = $urandom;
    tick();
    tick();
    total++;
    if (data_o !== '0) begin bad++; $display("[TB] FAIL reset_data got=%h want=0", data_o); end
    total++;
    if (Zero_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_zero got=%b want=1", Zero_o); end
    total++;
    if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", valid_o); end
    total++;
    if (ready_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", ready_o); end
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got=%b want=0", stall_o); end
    rst_i   = 1'b0;
    valid_i = 1'b0;
  endtask

  task automatic test_simple_ops();
    do_simple(3'b010, 32'd5, 32'd7);
    do_simple(3'b110, 32'd9, 32'd9);
    do_simple(3'b000, 32'hF0F0F0F0, 32'hFF00FF00);
    do_simple(3'b001, 32'h1, 32'h2);
    valid_i = 1'b0;
    tick();
    total++;
    if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL idle_valid got=%b want=0", valid_o); end
    total++;
    if (data_o !== 32'h3) begin bad++; $display("[TB] FAIL idle_hold got=%h want=3", data_o); end
  endtask

  task automatic test_mul();
    do_mul(32'hFFFFFFFF, 32'd2);
    do_mul(32'd6, 32'd7);
    do_mul(32'h10000, 32'h10000);
    for (int i = 0; i < 4; i++) do_mul($urandom, $urandom);
  endtask

  task automatic test_ignore_during_mul();
    int busy;
    int stray;
    valid_i   = 1'b1;
    ALUCtrl_i = 3'b011;
    data1_i   = 32'd3;
    data2_i   = 32'd4;
    tick();
    ALUCtrl_i = 3'b010;
    data1_i   = 32'd1;
    data2_i   = 32'd1;
    busy  = 0;
    stray = 0;
    while (valid_o !== 1'b1 && busy < 100) begin
      if (data_o === 32'd2) stray++;
      busy++;
      tick();
    end
    total++;
    if (busy != WIDTH) begin bad++; $display("[TB] FAIL ignore_busy got=%0d want=%0d", busy, WIDTH); end
    total++;
    if (stray != 0) begin bad++; $display("[TB] FAIL ignore_stray_add got=%0d want=0", stray); end
    total++;
    if (data_o !== 32'd12) begin bad++; $display("[TB] FAIL ignore_mul_data got=%h want=c", data_o); end
    tick();
    total++;
    if (valid_o !== 1'b1) begin bad++; $display("[TB] FAIL b2b_valid got=%b want=1", valid_o); end
    total++;
    if (data_o !== 32'd2) begin bad++; $display("[TB] FAIL b2b_data got=%h want=2", data_o); end
    valid_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_during_mul();
    int pulses;
    valid_i   = 1'b1;
    ALUCtrl_i = 3'b011;
    data1_i   = 32'd100;
    data2_i   = 32'd100;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst_i     = 1'b1;
    valid_i   = 1'b1;
    ALUCtrl_i = 3'b010;
    data1_i   = 32'd7;
    data2_i   = 32'd8;
    tick();
    rst_i   = 1'b0;
    valid_i = 1'b0;
    total++;
    if (data_o !== '0) begin bad++; $display("[TB] FAIL abort_data got=%h want=0", data_o); end
    total++;
    if (Zero_o !== 1'b1) begin bad++; $display("[TB] FAIL abort_zero got=%b want=1", Zero_o); end
    total++;
    if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL abort_valid got=%b want=0", valid_o); end
    total++;
    if (ready_o !== 1'b1) begin bad++; $display("[TB] FAIL abort_ready got=%b want=1", ready_o); end
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("[TB] FAIL abort_stall got=%b want=0", stall_o); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid_o === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) begin bad++; $display("[TB] FAIL abort_late_valid got=%0d want=0", pulses); end
    do_simple(3'b010, 32'd1, 32'd2);
    valid_i = 1'b0;
    tick();
  endtask

  task automatic test_undefined();
    do_simple(3'b111, 32'd5, 32'd5);
    do_simple(3'b001, 32'd8, 32'd0);
    do_simple(3'b100, $urandom, $urandom);
    do_simple(3'b101, $urandom, $urandom);
    valid_i = 1'b0;
    tick();
  endtask

  task automatic test_random_mix();
    logic [2:0] codes [7];
    logic [2:0] op;
    codes = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b011, 3'b100, 3'b111};
    for (int i = 0; i < 24; i++) begin
      op = codes[$urandom_range(0, 6)];
      if (op == 3'b011) do_mul($urandom, $urandom);
      else              do_simple(op, $urandom, $urandom);
    end
    valid_i = 1'b0;
    tick();
  endtask

  initial begin
    rst_i     = 1'b0;
    valid_i   = 1'b0;
    ALUCtrl_i = 3'b000;
    data1_i   = '0;
    data2_i   = '0;
    test_reset();
    test_simple_ops();
    test_mul();
    test_ignore_during_mul();
    test_reset_during_mul();
    test_undefined();
    test_random_mix();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
